uart_tx: RTL and testbench

//   UART transmitter paired with uart_rx: serialises one D_W-bit word per request
//   as 1 start bit (0), D_W data bits LSB first, then 1 stop bit (1).
//   Bit timing comes from the shared baud_gen oversampling tick (B_TICK ticks per bit).

---
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one start bit (0), D_W data bits LSB first, one stop bit (1).
// Bit timing comes from an external oversampling tick; a tick only counts when
// baud_clk and baud_en are both high. Every output is registered.
`timescale 1ns/1ps

module uart_tx #(
   parameter int D_W     = 8,
   parameter int B_TICK  = 16,
   parameter int SB_TICK = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           baud_clk,
   input  logic           baud_en,
   input  logic           tx_start,
   input  logic [D_W-1:0] in_data,
   output logic           tx_data,
   output logic           tx_busy,
   output logic           tx_done
);

   // Sample counter must reach the longer of the data-bit and stop-bit periods.
   localparam int CNT_MAX = (B_TICK > SB_TICK) ? B_TICK : SB_TICK;
   localparam int S_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int N_W     = (D_W > 1) ? $clog2(D_W) : 1;

   localparam logic [S_W-1:0] B_LAST  = S_W'(B_TICK - 1);
   localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
   localparam logic [N_W-1:0] N_LAST  = N_W'(D_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_e;

   state_e         state_q, state_d;
   logic [S_W-1:0] s_cnt_q, s_cnt_d;
   logic [N_W-1:0] n_q, n_d;
   logic [D_W-1:0] shreg_q, shreg_d;
   logic           tx_data_q, tx_data_d;
   logic           tx_busy_q, tx_busy_d;
   logic           tx_done_q, tx_done_d;

   logic tick;

   assign tick = baud_clk & baud_en;

   // State register and all registered outputs; reset is synchronous.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q   <= ST_IDLE;
         s_cnt_q   <= '0;
         n_q       <= '0;
         shreg_q   <= '0;
         tx_data_q <= 1'b1;
         tx_busy_q <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_cnt_q   <= s_cnt_d;
         n_q       <= n_d;
         shreg_q   <= shreg_d;
         tx_data_q <= tx_data_d;
         tx_busy_q <= tx_busy_d;
         tx_done_q <= tx_done_d;
      end
   end

   // Next-state, counter, shift-register and output logic.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d   = state_q;
      s_cnt_d   = s_cnt_q;
      n_d       = n_q;
      shreg_d   = shreg_q;
      tx_busy_d = tx_busy_q;
      tx_done_d = 1'b0;

      // Line level follows the current state; the register adds one cycle of lag.
      unique case (state_q)
         ST_START: tx_data_d = 1'b0;
         ST_DATA:  tx_data_d = shreg_q[0];
         default:  tx_data_d = 1'b1;
      endcase

      unique case (state_q)
         ST_IDLE: begin
            if (tx_start) begin
               shreg_d   = in_data;
               s_cnt_d   = '0;
               state_d   = ST_START;
               tx_busy_d = 1'b1;
            end
         end

         ST_START: begin
            if (tick) begin
               if (s_cnt_q == B_LAST) begin
                  s_cnt_d = '0;
                  n_d     = '0;
                  state_d = ST_DATA;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (s_cnt_q == B_LAST) begin
                  s_cnt_d = '0;
                  shreg_d = shreg_q >> 1;
                  if (n_q == N_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end

         ST_STOP: begin
            if (tick) begin
               if (s_cnt_q == SB_LAST) begin
                  s_cnt_d   = '0;
                  state_d   = ST_IDLE;
                  tx_busy_d = 1'b0;
                  tx_done_d = 1'b1;
               end else begin
                  s_cnt_d = s_cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign tx_data = tx_data_q;
   assign tx_busy = tx_busy_q;
   assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx: frame shape and timing, back-to-back frames,
// ignored requests while busy, baud_en gating, mid-frame reset and a full
// 0..255 sweep through a line decoder built into the bench.
`timescale 1ns/1ps

module tb_uart_tx;

   localparam int MAXREC = 1500;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_clk;
   logic       baud_en;
   logic       tx_start;
   logic [7:0] in_data;
   logic       tx_data;
   logic       tx_busy;
   logic       tx_done;

   int checks = 0;
   int errors = 0;

   // Baud tick generator: one-cycle pulse every tick_div clocks.
   int tick_div = 4;
   int bcnt     = 0;

   // Per-cycle recording of one frame, index 0 = first cycle after accept.
   logic ln [MAXREC];
   logic bz [MAXREC];
   logic dn [MAXREC];

   int runs [16];
   int nruns;

   uart_tx dut (
      .clk      (clk),
      .rst      (rst),
      .baud_clk (baud_clk),
      .baud_en  (baud_en),
      .tx_start (tx_start),
      .in_data  (in_data),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   initial forever #5 clk = ~clk;

   initial begin
      baud_clk = 1'b0;
      forever begin
         @(negedge clk);
         bcnt     = (bcnt + 1 >= tick_div) ? 0 : bcnt + 1;
         baud_clk = (bcnt == 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Requests one frame at the current negedge and records the line until tx_done.
   // poke_idx pulses tx_start with 0xFF; gate_idx drops baud_en for 200 clk.
   task automatic run_frame(input logic [7:0] data, input int poke_idx, input int gate_idx,
                            output int ncyc, output bit timeout);
      in_data  = data;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      in_data  = ~data;
      ncyc     = 0;
      timeout  = 1'b1;
      for (int i = 0; i < MAXREC; i++) begin
         if (i == poke_idx) begin
            tx_start = 1'b1;
            in_data  = 8'hFF;
         end else if (i == poke_idx + 1) begin
            tx_start = 1'b0;
         end
         if (i == gate_idx) baud_en = 1'b0;
         else if (i == gate_idx + 200) baud_en = 1'b1;
         ln[i] = tx_data;
         bz[i] = tx_busy;
         dn[i] = tx_done;
         ncyc  = i + 1;
         if (tx_done) begin
            timeout = 1'b0;
            break;
         end
         @(negedge clk);
      end
      baud_en = 1'b1;
   endtask

   // Mid-bit sampling decoder; returns {stop, data}.
   function automatic logic [8:0] decode(input int bitlen, input int ncyc);
      int s;
      int idx;
      logic [8:0] r;
      s = -1;
      r = 'x;
      for (int i = 0; i < ncyc; i++) begin
         if (ln[i] == 1'b0) begin
            s = i;
            break;
         end
      end
      if (s >= 0) begin
         for (int b = 0; b < 9; b++) begin
            idx  = s + bitlen * (b + 1) + bitlen / 2 - 1;
            r[b] = (idx < ncyc) ? ln[idx] : 1'bx;
         end
      end
      return r;
   endfunction

   // Run lengths of the recorded line from index 1 to the tx_done cycle.
   task automatic measure_runs(input int ncyc);
      logic cur;
      int   len;
      nruns = 0;
      cur   = ln[1];
      len   = 1;
      for (int i = 2; i < ncyc; i++) begin
         if (ln[i] == cur) begin
            len++;
         end else begin
            if (nruns < 16) runs[nruns] = len;
            nruns++;
            cur = ln[i];
            len = 1;
         end
      end
      if (nruns < 16) runs[nruns] = len;
      nruns++;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      baud_en  = 1'b1;
      tx_start = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_data, tx_busy, tx_done} !== 3'b100) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 100", {tx_data, tx_busy, tx_done});
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({tx_data, tx_busy, tx_done} !== 3'b100) begin
         errors++;
         $display("FAIL idle_after_reset: got %b expected 100", {tx_data, tx_busy, tx_done});
      end
   endtask

   task automatic test_single_frame();
      int n;
      bit to;
      int bad;
      run_frame(8'h55, -1, -1, n, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL t1_done_seen: got timeout expected tx_done");
      end
      checks++;
      if ({ln[0], bz[0], ln[1]} !== 3'b110) begin
         errors++;
         $display("FAIL t1_start_edge: got %b expected 110", {ln[0], bz[0], ln[1]});
      end
      checks++;
      if (decode(64, n) !== 9'h155) begin
         errors++;
         $display("FAIL t1_decode: got %h expected 155", decode(64, n));
      end
      measure_runs(n);
      checks++;
      if (nruns != 10) begin
         errors++;
         $display("FAIL t1_run_count: got %0d expected 10", nruns);
      end else begin
         checks++;
         if (runs[0] < 60 || runs[0] > 68) begin
            errors++;
            $display("FAIL t1_start_len: got %0d expected 60..68", runs[0]);
         end
         bad = 0;
         for (int i = 1; i < 9; i++) if (runs[i] != 64) bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL t1_data_len: got %0d bits not 64 clk expected 0", bad);
         end
         checks++;
         if (runs[9] != 64) begin
            errors++;
            $display("FAIL t1_stop_len: got %0d expected 64", runs[9]);
         end
      end
      bad = 0;
      for (int i = 0; i < n - 1; i++) if (bz[i] !== 1'b1) bad++;
      if (bz[n-1] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL t1_busy: got %0d bad cycles expected 0", bad);
      end
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_done !== 1'b0 || tx_data !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL t1_idle_after: got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int  n1, n2, s1, l1, stop1, f2, gap;
      bit  to1, to2;
      logic [8:0] d1;
      run_frame(8'hA3, -1, -1, n1, to1);
      d1 = decode(64, n1);
      s1 = -1;
      for (int i = 0; i < n1; i++) if (s1 < 0 && ln[i] == 1'b0) s1 = i;
      l1 = 0;
      for (int i = s1; i < n1 && ln[i] == 1'b0; i++) l1++;
      stop1 = s1 + l1 + 512;
      run_frame(8'h0F, -1, -1, n2, to2);
      checks++;
      if (to1 || to2) begin
         errors++;
         $display("FAIL t2_done_seen: got timeout %b%b expected 00", to1, to2);
      end
      checks++;
      if (d1 !== 9'h1A3) begin
         errors++;
         $display("FAIL t2_frame1: got %h expected 1a3", d1);
      end
      checks++;
      if (decode(64, n2) !== 9'h10F) begin
         errors++;
         $display("FAIL t2_frame2: got %h expected 10f", decode(64, n2));
      end
      f2 = -1;
      for (int i = 0; i < n2; i++) if (f2 < 0 && ln[i] == 1'b0) f2 = i;
      gap = (n1 + f2) - stop1;
      checks++;
      if (gap < 64 || gap > 65) begin
         errors++;
         $display("FAIL t2_stop_gap: got %0d expected 64..65", gap);
      end
   endtask

   task automatic test_ignore_busy();
      int n;
      bit to;
      int bad;
      run_frame(8'h00, 300, -1, n, to);
      checks++;
      if (to || decode(64, n) !== 9'h100) begin
         errors++;
         $display("FAIL t3_frame: got %h (timeout %b) expected 100", decode(64, n), to);
      end
      bad = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (tx_done !== 1'b0 || tx_data !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL t3_no_second_frame: got %0d bad cycles expected 0", bad);
      end
   endtask

   task automatic test_baud_gate();
      int n;
      bit to;
      run_frame(8'h08, -1, 285, n, to);
      measure_runs(n);
      checks++;
      if (to || nruns != 4) begin
         errors++;
         $display("FAIL t4_shape: got %0d runs (timeout %b) expected 4", nruns, to);
      end else begin
         checks++;
         if (runs[0] < 252 || runs[0] > 260) begin
            errors++;
            $display("FAIL t4_pre_len: got %0d expected 252..260", runs[0]);
         end
         checks++;
         if (runs[1] != 264) begin
            errors++;
            $display("FAIL t4_bit3_len: got %0d expected 264", runs[1]);
         end
         checks++;
         if (runs[2] != 256 || runs[3] != 64) begin
            errors++;
            $display("FAIL t4_post_len: got %0d/%0d expected 256/64", runs[2], runs[3]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      bit to;
      int bad;
      in_data  = 8'h00;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (412) @(negedge clk);
      checks++;
      if (tx_data !== 1'b0 || tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL t5_in_bit5: got data %b busy %b expected 0 1", tx_data, tx_busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({tx_data, tx_busy, tx_done} !== 3'b100) begin
         errors++;
         $display("FAIL t5_after_reset: got %b expected 100", {tx_data, tx_busy, tx_done});
      end
      bad = 0;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         if (tx_done !== 1'b0 || tx_data !== 1'b1 || tx_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL t5_aborted: got %0d bad cycles expected 0", bad);
      end
      run_frame(8'h3C, -1, -1, n, to);
      checks++;
      if (to || decode(64, n) !== 9'h13C) begin
         errors++;
         $display("FAIL t5_new_frame: got %h (timeout %b) expected 13c", decode(64, n), to);
      end
   endtask

   task automatic test_sweep();
      int n;
      bit to;
      logic [8:0] got;
      logic [7:0] v8;
      tick_div = 1;
      for (int v = 0; v < 256; v++) begin
         v8 = 8'(v);
         run_frame(v8, -1, -1, n, to);
         got = decode(16, n);
         checks++;
         if (to || got !== {1'b1, v8}) begin
            errors++;
            $display("FAIL t6_sweep: got %h (timeout %b) expected %h", got, to, {1'b1, v8});
         end
      end
      tick_div = 4;
   endtask

   initial begin
      rst      = 1'b1;
      baud_en  = 1'b1;
      tx_start = 1'b0;
      in_data  = 8'h00;
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_ignore_busy();
      test_baud_gate();
      test_reset_mid_frame();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
